// File: rtl/spi_master_multi.sv
// SPI master: per-command CPOL/CPHA and bit count, parametrised setup/divider/gap timing,
// MISO captured into a right-aligned response word.
module spi_master_multi #(
  parameter int DATA_W    = 16,
  parameter int NUM_SS    = 8,
  parameter int CLK_DIV   = 20,
  parameter int SETUP_CYC = 20,
  parameter int END_CYC   = 15,
  parameter int MSB_FIRST = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [DATA_W-1:0]           cmd_data,
  input  logic [$clog2(DATA_W+1)-1:0] cmd_len,
  input  logic [NUM_SS-1:0]           cmd_ss,
  input  logic                        cmd_cpol,
  input  logic                        cmd_cpha,
  output logic                        rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic                        busy,
  output logic                        SPI_CLK,
  output logic                        MOSI,
  input  logic                        MISO,
  output logic [NUM_SS-1:0]           SPI_SS
);

  localparam int LEN_W   = $clog2(DATA_W + 1);
  localparam int TGL_W   = LEN_W + 1;
  localparam int CNT_MAX = (SETUP_CYC > CLK_DIV + END_CYC) ? SETUP_CYC : CLK_DIV + END_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [LEN_W-1:0] DW_L       = LEN_W'(DATA_W);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
  // Ready is raised one edge early so the next accept lands END_CYC edges after SS rises.
  localparam logic [CNT_W-1:0] END_LAST   = CNT_W'(CLK_DIV + END_CYC - 2);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_XFER, ST_END} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [TGL_W-1:0]    tgl;
  logic [LEN_W-1:0]    len;
  logic                cpol, cpha;
  logic [NUM_SS-1:0]   ss_mask;
  logic [DATA_W-1:0]   tx_sr, rx_sr;

  logic [LEN_W-1:0]    len_clamp;
  logic [DATA_W-1:0]   tx_shift, rx_next;
  logic                cur_bit, next_bit;
  logic                do_toggle, lead_tgl, last_tgl;

  assign len_clamp = (cmd_len == '0 || cmd_len > DW_L) ? DW_L : cmd_len;
  assign lead_tgl  = ~tgl[0];
  assign last_tgl  = (tgl == {len, 1'b0} - TGL_W'(1));
  assign do_toggle = (state == ST_SETUP && cnt == SETUP_LAST) ||
                     (state == ST_XFER  && cnt == DIV_LAST);

  always_comb begin
    // NOTE: every signal gets a default first so no latch is inferred.
    cur_bit  = tx_sr[0];
    tx_shift = tx_sr >> 1;
    rx_next  = {MISO, rx_sr[DATA_W-1:1]};
    if (MSB_FIRST != 0) begin
      cur_bit  = tx_sr[DATA_W-1];
      tx_shift = tx_sr << 1;
      rx_next  = {rx_sr[DATA_W-2:0], MISO};
    end
    next_bit = (MSB_FIRST != 0) ? tx_shift[DATA_W-1] : tx_shift[0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      tgl       <= '0;
      len       <= '0;
      cpol      <= 1'b0;
      cpha      <= 1'b0;
      ss_mask   <= '0;
      // NOTE: the shift registers are reset too, so an aborted transfer leaves no stale bits.
      tx_sr     <= '0;
      rx_sr     <= '0;
      cmd_ready <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      SPI_CLK   <= 1'b0;
      MOSI      <= 1'b0;
      SPI_SS    <= '1;
    end else begin
      // NOTE: all sequential state is updated with non-blocking assignments.
      rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_ready && cmd_valid) begin
            state     <= ST_SETUP;
            cnt       <= '0;
            tgl       <= '0;
            len       <= len_clamp;
            cpol      <= cmd_cpol;
            cpha      <= cmd_cpha;
            ss_mask   <= cmd_ss;
            // Left-align MSB-first data so the first bit always sits at the top.
            tx_sr     <= (MSB_FIRST != 0) ? cmd_data << (DW_L - len_clamp) : cmd_data;
            rx_sr     <= '0;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (cnt == '0) begin
            SPI_SS  <= ~ss_mask;
            SPI_CLK <= cpol;
            MOSI    <= cpha ? 1'b0 : cur_bit;
          end
          if (cnt == SETUP_LAST) begin
            state <= ST_XFER;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_XFER: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (last_tgl) state <= ST_END;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_END: begin
          if (cnt == DIV_LAST) begin
            SPI_SS    <= '1;
            MOSI      <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= (MSB_FIRST != 0) ? rx_sr : rx_sr >> (DW_L - len);
          end
          if (cnt == END_LAST) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (do_toggle) begin
        SPI_CLK <= ~SPI_CLK;
        tgl     <= tgl + TGL_W'(1);
        if (lead_tgl) begin
          if (cpha) begin
            MOSI  <= cur_bit;
            tx_sr <= tx_shift;
          end else begin
            rx_sr <= rx_next;
          end
        end else begin
          if (cpha) begin
            rx_sr <= rx_next;
          end else if (!last_tgl) begin
            MOSI  <= next_bit;
            tx_sr <= tx_shift;
          end
        end
      end
    end
  end

endmodule

// File: doc/spi_master_multi.md
Name: spi_master_multi

Overview:
- Next-generation SPI master for sensor/LDO/DAC configuration.
- Width, chip-select count, clock divider and setup/gap timing are all parametrised. SPI mode (CPOL/CPHA) and bit count are chosen per transfer.
- Captures MISO into a response word.
- Single clock domain, fed by a valid/ready command interface from the host-side command FIFO/sequencer.

Parameters:
- DATA_W, 16, maximum bits per transfer (2..32).
- NUM_SS, 8, number of chip-select lines.
- CLK_DIV, 20, clk cycles per SPI_CLK half-period (>=2).
- SETUP_CYC, 20, cycles from SS assertion to first SPI_CLK edge (>=1).
- END_CYC, 15, minimum SS-high gap after a transfer before cmd_ready returns (>=1).
- MSB_FIRST, 1, 1 = shift MSB first; 0 = LSB first.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_data  in  DATA_W  bits to send, right-aligned in the low cmd_len bits.
- cmd_len  in  $clog2(DATA_W+1)  bits to transfer; 0 is treated as DATA_W; values >DATA_W are clamped to DATA_W.
- cmd_ss  in  NUM_SS  one-hot/multi-hot select mask (1 = select).
- cmd_cpol  in  1  idle clock level.
- cmd_cpha  in  1  clock phase.
- rsp_valid  out  1  one-cycle pulse, response ready.
- rsp_data  out  DATA_W  received bits, right-aligned; unused MSBs are 0.
- busy  out  1  high from accept until cmd_ready returns.
- SPI_CLK  out  1  serial clock.
- MOSI  out  1  serial data out.
- MISO  in  1  serial data in.
- SPI_SS  out  NUM_SS  active-low chip selects.

Behaviour:

Reset (rst=0, asynchronous):
- State IDLE.
- SPI_SS all 1; SPI_CLK 0; MOSI 0.
- cmd_ready 0; rsp_valid 0; rsp_data 0; busy 0.
- cmd_ready rises on the first clk edge after rst deasserts.
- Reset mid-transfer aborts immediately: SS deasserts, no rsp_valid is produced.

Outputs:
- SPI_CLK, MOSI, SPI_SS, cmd_ready, rsp_valid and busy all come directly from flops, so they are glitch-free.

Handshake:
- Accept on the edge where cmd_valid && cmd_ready.
- cmd_ready is high only in IDLE.
- All cmd_* fields are latched at accept; later changes are ignored.

FSM states: IDLE -> SETUP -> XFER -> END -> IDLE.
- IDLE: outputs at idle (SS high). SPI_CLK is held at the CPOL of the last transfer (0 after reset).
- SETUP: entered at accept edge k.
  - At edge k+1: SPI_SS = ~cmd_ss; SPI_CLK = cpol.
  - If cpha=0, MOSI = first bit at k+1. If cpha=1, MOSI = 0 until the first edge.
  - Lasts SETUP_CYC cycles; first SPI_CLK toggle at k+1+SETUP_CYC.
- XFER: 2*len toggles, each CLK_DIV cycles apart.
  - Leading edge = odd toggle; trailing edge = even toggle.
  - cpha=0: sample MISO at leading edge; drive next bit at trailing edge (except after the last bit).
  - cpha=1: drive bit at leading edge; sample at trailing edge.
  - Sampling is from the clk-domain value of MISO in the cycle the edge is issued.
  - Bit order per MSB_FIRST. Bit counter counts down from len; leaves XFER after the final toggle.
- END:
  - CLK_DIV cycles after the final toggle, SPI_SS goes all 1 and MOSI goes 0.
  - rsp_valid pulses on that same edge with rsp_data valid; rsp_data holds until the next rsp_valid.
  - SS stays high END_CYC cycles, then cmd_ready=1.
  - A back-to-back command held on cmd_valid is accepted on the first ready cycle, so the minimum SS-high gap is END_CYC+1 cycles.
- busy = ~cmd_ready outside reset.

Total command period: 1 + SETUP_CYC + 2*len*CLK_DIV + END_CYC cycles, accept to next ready.

Test Plan:
1. Mode 0, DATA_W=16, CLK_DIV=4, SETUP_CYC=3, END_CYC=2, MSB_FIRST=1. cmd_data=0xA5C3, cmd_len=0, cmd_ss=0x04, accepted at edge k.
   - SPI_SS=0xFB from k+1 to k+131; SS high at k+132.
   - 16 rising edges; MOSI sequence 1010010111000011.
   - cmd_ready high again at k+134.
2. Mode 3 loopback (MISO=MOSI), cmd_data=0x3C5A, cmd_len=16 -> SPI_CLK idles 1, MOSI changes on falling edges, rsp_valid single pulse with rsp_data=0x3C5A.
3. cmd_len=5, cmd_data=0x0013, MSB_FIRST=0, MISO tied 1 -> exactly 10 toggles, MOSI 1,1,0,0,1, rsp_data=0x001F.
4. Two commands with cmd_valid held high (ss 0x01 then 0x80) -> SPI_SS gap of exactly END_CYC+1 cycles all-1; never two SS bits low simultaneously; the cmd_data change after the first accept does not affect the first transfer.
5. Assert rst low during bit 7 of a transfer -> same cycle SPI_SS=all 1, SPI_CLK=0, MOSI=0, no rsp_valid; after release a fresh command completes normally.
6. cmd_len=20 with DATA_W=16 -> clamped to 16 bits (32 toggles); cmd_valid low for 50 cycles -> cmd_ready stays 1, all outputs static.
